// File: rtl/write_back_buffer_if.sv
// Bus bundle for write_back_buffer: eviction push, refill lookup and RAM write port.
// The master modport is the upstream/RAM side, the slave modport is the buffer itself.
interface write_back_buffer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int DEPTH          = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      push_en;
    logic [RAM_ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0]     push_data;
    logic                      full;
    logic                      empty;
    logic [CNT_W-1:0]          count;
    logic                      lookup_en;
    logic [RAM_ADDR_WIDTH-1:0] lookup_addr;
    logic                      lookup_hit;
    logic [DATA_WIDTH-1:0]     lookup_data;
    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wd;
    logic                      ram_ack;

    modport master (
        output push_en, push_addr, push_data, lookup_en, lookup_addr, ram_ack,
        input  full, empty, count, lookup_hit, lookup_data, ram_we, ram_addr, ram_wd
    );

    modport slave (
        input  push_en, push_addr, push_data, lookup_en, lookup_addr, ram_ack,
        output full, empty, count, lookup_hit, lookup_data, ram_we, ram_addr, ram_wd
    );
endinterface

// File: rtl/write_back_buffer.sv
// Write-back FIFO between cache controller and RAM, with refill-path forwarding.
// Optional WBB_COALESCE_EN: pushes to an address already buffered (not in flight) merge in place.
module write_back_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int DEPTH          = 4
) (
    input logic                clk,
    input logic                rst_n,
    write_back_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WA_W  = RAM_ADDR_WIDTH - 2;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                    r_state;
    logic [WA_W-1:0]           r_addr [DEPTH];
    logic [DATA_WIDTH-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0]          r_valid;
    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W-1:0]          r_rptr;
    logic [CNT_W-1:0]          r_count;
    logic                      r_ram_we;
    logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0]     r_ram_wd;

    logic                      w_pop;
    logic                      w_has_room;
    logic                      w_alloc;
    logic                      w_merge;
    logic [PTR_W-1:0]          w_merge_idx;
    logic [DATA_WIDTH-1:0]     w_head_wd;
    logic                      w_lookup_hit;
    logic [DATA_WIDTH-1:0]     w_lookup_data;
    logic [WA_W-1:0]           w_push_wa;
    logic [WA_W-1:0]           w_lookup_wa;

    assign w_push_wa   = bus.push_addr[RAM_ADDR_WIDTH-1:2];
    assign w_lookup_wa = bus.lookup_addr[RAM_ADDR_WIDTH-1:2];
    assign w_pop       = (r_state == S_WRITE) && bus.ram_ack;
    assign w_has_room  = (r_count != CNT_W'(DEPTH)) || w_pop;
    assign w_alloc     = bus.push_en && !w_merge && w_has_room;

`ifdef WBB_COALESCE_EN
    always_comb begin
        w_merge     = 1'b0;
        w_merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == w_push_wa) &&
                !((r_state == S_WRITE) && (PTR_W'(i) == r_rptr))) begin
                w_merge     = bus.push_en;
                w_merge_idx = PTR_W'(i);
            end
        end
    end
`else
    assign w_merge     = 1'b0;
    assign w_merge_idx = '0;
`endif

    // A merge into the head on the cycle it gets latched must reach RAM too.
    assign w_head_wd = (w_merge && (w_merge_idx == r_rptr)) ? bus.push_data : r_data[r_rptr];

    // Walk entries oldest to youngest so the youngest match is left standing.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx           = '0;
        w_lookup_hit  = 1'b0;
        w_lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + PTR_W'(i);
            if (bus.lookup_en && r_valid[idx] && (r_addr[idx] == w_lookup_wa)) begin
                w_lookup_hit  = 1'b1;
                w_lookup_data = r_data[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_wptr] <= w_push_wa;
            r_data[r_wptr] <= bus.push_data;
        end else if (w_merge) begin
            r_data[w_merge_idx] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_wd   <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + PTR_W'(1);
            end
            if (w_alloc) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= {r_addr[r_rptr], 2'b00};
                        r_ram_wd   <= w_head_wd;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.ram_ack) begin
                        r_ram_we <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.full        = (r_count == CNT_W'(DEPTH));
    assign bus.empty       = (r_count == '0);
    assign bus.count       = r_count;
    assign bus.lookup_hit  = w_lookup_hit;
    assign bus.lookup_data = w_lookup_data;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wd      = r_ram_wd;
endmodule

// File: tb/tb_write_back_buffer.sv
// Self-checking bench for write_back_buffer: RAM-write scoreboard, lookup vector table,
// and hand sequences for fill/full, mid-transfer reset and pointer wrap.
module tb_write_back_buffer;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    write_back_buffer_if #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    write_back_buffer #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic          exp_hit;
        logic [DW-1:0] exp_data;
    } lk_vec_t;

    wr_t  exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic ack_en    = 1'b0;
    logic ack_force = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: decide ack for the coming edge, score any write it completes.
    task automatic tick();
        wr_t e;
        bus.ram_ack = ack_force | (ack_en & bus.ram_we);
        if (bus.ram_we && bus.ram_ack) begin
            if (exp_q.size() == 0) begin
                check("ram_unexpected_write", {32'h0, bus.ram_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("ram_addr_order", bus.ram_addr, e.addr);
                check("ram_wd_order", bus.ram_wd, e.data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_wr);
        wr_t e;
        bus.push_en   = 1'b1;
        bus.push_addr = a;
        bus.push_data = d;
        if (expect_wr) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        tick();
        bus.push_en = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && !bus.empty; i++) tick();
        check({name, "_empty"}, bus.empty, 1);
        check({name, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        lk_vec_t vecs[7];
        int  k;
        int  max_cnt;
        wr_t e;

        vecs[0] = '{1'b1, 32'h200, 1'b1, 32'h1111_1111};
        vecs[1] = '{1'b1, 32'h204, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h200, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h300, 1'b1, 32'h0000_000B};
        vecs[4] = '{1'b1, 32'h400, 1'b1, 32'h2222_2222};
        vecs[5] = '{1'b1, 32'h500, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h203, 1'b1, 32'h1111_1111};

        rst_n           = 1'b0;
        bus.push_en     = 1'b0;
        bus.push_addr   = '0;
        bus.push_data   = '0;
        bus.lookup_en   = 1'b0;
        bus.lookup_addr = '0;
        bus.ram_ack     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wd", bus.ram_wd, 0);
        check("rst_count", bus.count, 0);
        check("rst_full", bus.full, 0);
        check("rst_empty", bus.empty, 1);

        // Single push, long-held request, then ack.
        drive_push(32'h100, 32'hDEAD_BEEF, 1);
        check("t1_count_after_push", bus.count, 1);
        check("t1_we_not_yet", bus.ram_we, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_we", bus.ram_we, 1);
            check("t1_hold_addr", bus.ram_addr, 32'h100);
            check("t1_hold_wd", bus.ram_wd, 32'hDEAD_BEEF);
        end
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        check("t1_count_after_ack", bus.count, 0);
        check("t1_we_after_ack", bus.ram_we, 0);
        check("t1_empty_after_ack", bus.empty, 1);
        check("t1_sb_left", exp_q.size(), 0);

        // Fill to full, push while full with same-cycle pop, drain in order.
        drive_push(32'h10, 32'h0000_1010, 1);
        drive_push(32'h20, 32'h0000_2020, 1);
        drive_push(32'h30, 32'h0000_3030, 1);
        drive_push(32'h40, 32'h0000_4040, 1);
        check("t2_full", bus.full, 1);
        check("t2_count4", bus.count, 4);
        check("t2_we_busy", bus.ram_we, 1);
        ack_en = 1'b1;
        drive_push(32'h50, 32'h0000_5050, 1);
        check("t2_count_push_pop", bus.count, 4);
        check("t2_full_push_pop", bus.full, 1);
        drain("t2");
        ack_en = 1'b0;

        // Lookup forwarding with a duplicate address.
        drive_push(32'h200, 32'h1111_1111, 1);
        drive_push(32'h300, 32'h0000_000A, 1);
`ifdef WBB_COALESCE_EN
        drive_push(32'h300, 32'h0000_000B, 0);
        exp_q[1].data = 32'h0000_000B;
        k = 3;
`else
        drive_push(32'h300, 32'h0000_000B, 1);
        k = 4;
`endif
        drive_push(32'h400, 32'h2222_2222, 1);
        check("t3_count_dup", bus.count, k[2:0]);
        for (int i = 0; i < 7; i++) begin
            bus.lookup_en   = vecs[i].en;
            bus.lookup_addr = vecs[i].addr;
            #1;
            check($sformatf("lookup_hit_%0d", i), bus.lookup_hit, vecs[i].exp_hit);
            check($sformatf("lookup_data_%0d", i), bus.lookup_data, vecs[i].exp_data);
        end
        bus.lookup_en = 1'b0;
        ack_en = 1'b1;
        drain("t3");
        ack_en = 1'b0;

        // Reset in the middle of a transfer.
        drive_push(32'h600, 32'h6666_0000, 1);
        drive_push(32'h604, 32'h6666_0004, 1);
        drive_push(32'h608, 32'h6666_0008, 1);
        check("t4_count3", bus.count, 3);
        check("t4_we_busy", bus.ram_we, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("t4_rst_we", bus.ram_we, 0);
        check("t4_rst_count", bus.count, 0);
        check("t4_rst_empty", bus.empty, 1);
        ack_force = 1'b1;
        tick();
        check("t4_stray_ack_count", bus.count, 0);
        check("t4_stray_ack_we", bus.ram_we, 0);
        // Ack during IDLE must not pop the entry being pushed.
        drive_push(32'h700, 32'h7777_7777, 1);
        check("t4_idle_ack_count", bus.count, 1);
        check("t4_idle_ack_we", bus.ram_we, 0);
        tick();
        check("t4_idle_ack_count2", bus.count, 1);
        check("t4_idle_ack_we2", bus.ram_we, 1);
        check("t4_idle_ack_addr", bus.ram_addr, 32'h700);
        tick();
        ack_force = 1'b0;
        check("t4_final_count", bus.count, 0);
        check("t4_sb_left", exp_q.size(), 0);

        // 12 pushes with upstream stalling on full, continuous ack: three wraps.
        ack_en  = 1'b1;
        k       = 0;
        max_cnt = 0;
        for (int c = 0; c < 200 && (k < 12 || !bus.empty); c++) begin
            if (k < 12 && (bus.count < 3'd4 || bus.ram_we)) begin
                e.addr = 32'h1000 + 32'(k) * 32'h10;
                e.data = $urandom;
                exp_q.push_back(e);
                bus.push_en   = 1'b1;
                bus.push_addr = e.addr;
                bus.push_data = e.data;
                k++;
            end else begin
                bus.push_en = 1'b0;
            end
            tick();
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        end
        bus.push_en = 1'b0;
        ack_en      = 1'b0;
        check("t5_pushes", k, 12);
        check("t5_max_count", max_cnt, 4);
        check("t5_empty", bus.empty, 1);
        check("t5_sb_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
